// File: rtl/mem_access_stage.sv
// ============================================================================
//  Module   : mem_access_stage
//  Purpose  : MEM stage between EX and WB. Drives the word RAM, extends
//             sub-word loads, runs SB/SH as a 2-cycle read-modify-write and
//             registers the MEM/WB result.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_stage #(
  parameter int ADDR_W = 7,
  parameter int DA_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [31:0]       in_addr,
  input  logic [31:0]       in_wdata,
  input  logic [DA_W-1:0]   in_da,
  input  logic              in_rw,
  output logic [ADDR_W-1:0] RAA,
  output logic              MW,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [31:0]       wb_data,
  output logic [DA_W-1:0]   wb_da,
  output logic              wb_rw,
  output logic              wb_err
);

  localparam logic [3:0] c_op_nop = 4'b0000;
  localparam logic [3:0] c_op_lw  = 4'b0001;
  localparam logic [3:0] c_op_lh  = 4'b0010;
  localparam logic [3:0] c_op_lhu = 4'b0011;
  localparam logic [3:0] c_op_lb  = 4'b0100;
  localparam logic [3:0] c_op_lbu = 4'b0101;
  localparam logic [3:0] c_op_sw  = 4'b1001;
  localparam logic [3:0] c_op_sh  = 4'b1010;
  localparam logic [3:0] c_op_sb  = 4'b1100;

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_RMW_WRITE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         rmw_word_q, rmw_word_d;
  logic [15:0]         rmw_data_q, rmw_data_d;
  logic [1:0]          rmw_lane_q, rmw_lane_d;
  logic                rmw_byte_q, rmw_byte_d;
  logic [ADDR_W-1:0]   rmw_idx_q,  rmw_idx_d;
  logic [DA_W-1:0]     rmw_da_q,   rmw_da_d;

  logic                wb_valid_q, wb_valid_d;
  logic [31:0]         wb_data_q,  wb_data_d;
  logic [DA_W-1:0]     wb_da_q,    wb_da_d;
  logic                wb_rw_q,    wb_rw_d;
  logic                wb_err_q,   wb_err_d;

  logic [1:0]          lane;
  logic [ADDR_W-1:0]   word_idx;
  logic                op_legal, op_load, op_sub_store, op_aligned, op_ok;
  logic                accept, mw_raw;
  logic [7:0]          lane_byte;
  logic [15:0]         lane_half;
  logic [31:0]         load_data, merged_word;

  // Address bits above the RAM size are intentionally dropped (wrap-around).
  logic unused_addr_hi;
  assign unused_addr_hi = &{1'b0, in_addr[31:ADDR_W+2]};

  assign lane     = in_addr[1:0];
  assign word_idx = in_addr[ADDR_W+1:2];
  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid & in_ready;
  assign op_ok    = op_legal & op_aligned;

  always_comb begin
    op_legal     = 1'b1;
    op_load      = 1'b0;
    op_sub_store = 1'b0;
    op_aligned   = 1'b1;
    case (in_op)
      c_op_nop:           ;
      c_op_lw:            begin op_load = 1'b1; op_aligned = (lane == 2'b00); end
      c_op_lh, c_op_lhu:  begin op_load = 1'b1; op_aligned = ~lane[0]; end
      c_op_lb, c_op_lbu:  op_load = 1'b1;
      c_op_sw:            op_aligned = (lane == 2'b00);
      c_op_sh:            begin op_sub_store = 1'b1; op_aligned = ~lane[0]; end
      c_op_sb:            op_sub_store = 1'b1;
      default:            op_legal = 1'b0;
    endcase
  end

  always_comb begin
    lane_byte = mem_rdata[7:0];
    case (lane)
      2'd1:    lane_byte = mem_rdata[15:8];
      2'd2:    lane_byte = mem_rdata[23:16];
      2'd3:    lane_byte = mem_rdata[31:24];
      default: lane_byte = mem_rdata[7:0];
    endcase
    lane_half = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    load_data = mem_rdata;
    case (in_op)
      c_op_lb:  load_data = {{24{lane_byte[7]}}, lane_byte};
      c_op_lbu: load_data = {24'd0, lane_byte};
      c_op_lh:  load_data = {{16{lane_half[15]}}, lane_half};
      c_op_lhu: load_data = {16'd0, lane_half};
      default:  load_data = mem_rdata;
    endcase
  end

  always_comb begin
    merged_word = rmw_word_q;
    if (rmw_byte_q) begin
      case (rmw_lane_q)
        2'd1:    merged_word[15:8]  = rmw_data_q[7:0];
        2'd2:    merged_word[23:16] = rmw_data_q[7:0];
        2'd3:    merged_word[31:24] = rmw_data_q[7:0];
        default: merged_word[7:0]   = rmw_data_q[7:0];
      endcase
    end else if (rmw_lane_q[1]) begin
      merged_word[31:16] = rmw_data_q;
    end else begin
      merged_word[15:0] = rmw_data_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    rmw_word_d = rmw_word_q;
    rmw_data_d = rmw_data_q;
    rmw_lane_d = rmw_lane_q;
    rmw_byte_d = rmw_byte_q;
    rmw_idx_d  = rmw_idx_q;
    rmw_da_d   = rmw_da_q;
    wb_valid_d = 1'b0;
    wb_data_d  = 32'd0;
    wb_da_d    = '0;
    wb_rw_d    = 1'b0;
    wb_err_d   = 1'b0;
    RAA        = word_idx;
    mem_wdata  = in_wdata;
    mw_raw     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        mw_raw = accept & (in_op == c_op_sw) & op_ok;
        if (accept) begin
          if (op_sub_store & op_ok) begin
            // Retirement is deferred to the write cycle.
            state_d    = ST_RMW_WRITE;
            rmw_word_d = mem_rdata;
            rmw_data_d = in_wdata[15:0];
            rmw_lane_d = lane;
            rmw_byte_d = (in_op == c_op_sb);
            rmw_idx_d  = word_idx;
            rmw_da_d   = in_da;
          end else begin
            wb_valid_d = 1'b1;
            wb_da_d    = in_da;
            wb_err_d   = ~op_ok;
            wb_rw_d    = op_load & op_ok & in_rw;
            wb_data_d  = (op_load & op_ok) ? load_data : 32'd0;
          end
        end
      end
      ST_RMW_WRITE: begin
        RAA        = rmw_idx_q;
        mem_wdata  = merged_word;
        mw_raw     = 1'b1;
        state_d    = ST_IDLE;
        wb_valid_d = 1'b1;
        wb_da_d    = rmw_da_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Gating by reset also abandons an in-flight RMW write.
  assign MW = mw_raw & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rmw_word_q <= 32'd0;
      rmw_data_q <= 16'd0;
      rmw_lane_q <= 2'd0;
      rmw_byte_q <= 1'b0;
      rmw_idx_q  <= '0;
      rmw_da_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= 32'd0;
      wb_da_q    <= '0;
      wb_rw_q    <= 1'b0;
      wb_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rmw_word_q <= rmw_word_d;
      rmw_data_q <= rmw_data_d;
      rmw_lane_q <= rmw_lane_d;
      rmw_byte_q <= rmw_byte_d;
      rmw_idx_q  <= rmw_idx_d;
      rmw_da_q   <= rmw_da_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_da_q    <= wb_da_d;
      wb_rw_q    <= wb_rw_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_data  = wb_data_q;
  assign wb_da    = wb_da_q;
  assign wb_rw    = wb_rw_q;
  assign wb_err   = wb_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
//  Module   : tb_mem_access_stage
//  Purpose  : Directed plus randomized bench for mem_access_stage against a
//             word-array reference memory and arithmetic load/store rules.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_access_stage;

  localparam int ADDR_W = 7;
  localparam int DA_W   = 5;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [31:0]       in_addr;
  logic [31:0]       in_wdata;
  logic [DA_W-1:0]   in_da;
  logic              in_rw;
  logic [ADDR_W-1:0] RAA;
  logic              MW;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              wb_valid;
  logic [31:0]       wb_data;
  logic [DA_W-1:0]   wb_da;
  logic              wb_rw;
  logic              wb_err;

  logic [31:0] ram     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(ADDR_W), .DA_W(DA_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_da(in_da), .in_rw(in_rw),
    .RAA(RAA), .MW(MW), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_da(wb_da),
    .wb_rw(wb_rw), .wb_err(wb_err)
  );

  assign mem_rdata = ram[RAA];
  always_ff @(posedge clk) if (MW) ram[RAA] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one op from a cycle start and checks it through retirement.
  task automatic do_op(input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] da, input logic rw);
    int          idx, sh;
    bit          legal, is_load, is_sub, aligned, err;
    logic [31:0] word, v, exp_data, mask, merged;
    idx     = int'(addr[ADDR_W+1:2]);
    sh      = int'(addr[1:0]) * 8;
    legal   = (op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd12});
    is_load = (op >= 4'd1 && op <= 4'd5);
    is_sub  = (op == 4'd10 || op == 4'd12);
    aligned = 1'b1;
    if (op == 4'd1 || op == 4'd9) aligned = (addr[1:0] == 2'b00);
    if (op == 4'd2 || op == 4'd3 || op == 4'd10) aligned = (addr[0] == 1'b0);
    err = !legal || !aligned;

    word     = ref_mem[idx];
    v        = word >> sh;
    exp_data = 32'd0;
    if (is_load && !err) begin
      case (op)
        4'd1:    exp_data = word;
        4'd2:    exp_data = {{16{v[15]}}, v[15:0]};
        4'd3:    exp_data = {16'd0, v[15:0]};
        4'd4:    exp_data = {{24{v[7]}}, v[7:0]};
        default: exp_data = {24'd0, v[7:0]};
      endcase
    end

    in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wdata; in_da = da; in_rw = rw;
    #3;
    check("ready_idle", {31'd0, in_ready}, 32'd1);
    check("raa", {25'd0, RAA}, idx);
    check("mw_accept", {31'd0, MW}, {31'd0, (op == 4'd9) && !err});
    if (op == 4'd9 && !err) check("sw_wdata", mem_wdata, wdata);
    @(posedge clk); #1;

    if (is_sub && !err) begin
      mask   = (op == 4'd12) ? 32'h0000_00FF : 32'h0000_FFFF;
      merged = (word & ~(mask << sh)) | ((wdata & mask) << sh);
      in_valid = 1'b0;
      in_op    = 4'($urandom_range(0, 15));
      in_addr  = $urandom;
      check("rmw_ready", {31'd0, in_ready}, 32'd0);
      check("rmw_wbv", {31'd0, wb_valid}, 32'd0);
      check("rmw_mw", {31'd0, MW}, 32'd1);
      check("rmw_raa", {25'd0, RAA}, idx);
      check("rmw_wdata", mem_wdata, merged);
      ref_mem[idx] = merged;
      @(posedge clk); #1;
    end else if (op == 4'd9 && !err) begin
      ref_mem[idx] = wdata;
    end

    check("wb_valid", {31'd0, wb_valid}, 32'd1);
    check("wb_data", wb_data, exp_data);
    check("wb_rw", {31'd0, wb_rw}, {31'd0, is_load && !err && rw});
    check("wb_err", {31'd0, wb_err}, {31'd0, err});
    check("wb_da", {27'd0, wb_da}, {27'd0, da});
    in_valid = 1'b0;
  endtask

  initial begin
    logic [3:0]  op_tab [12];
    logic [31:0] a;
    op_tab = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd12, 4'd0, 4'd6, 4'd15, 4'd11};
    for (int i = 0; i < DEPTH; i++) begin ram[i] = i; ref_mem[i] = i; end
    reset = 1'b1; in_valid = 1'b0; in_op = 4'd0; in_addr = 32'd0;
    in_wdata = 32'd0; in_da = '0; in_rw = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wbv", {31'd0, wb_valid}, 32'd0);
    check("rst_wbdata", wb_data, 32'd0);
    check("rst_wberr", {31'd0, wb_err}, 32'd0);
    check("rst_mw", {31'd0, MW}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", {31'd0, in_ready}, 32'd1);

    do_op(4'd1, 32'h14, 32'h0, 5'd3, 1'b1);
    check("lw14_val", wb_data, 32'h0000_0005);
    do_op(4'd1, 32'h214, 32'h0, 5'd4, 1'b1);
    do_op(4'd9, 32'h08, 32'hDEADBEEF, 5'd1, 1'b1);
    do_op(4'd1, 32'h08, 32'h0, 5'd2, 1'b0);
    check("lw08_val", wb_data, 32'hDEADBEEF);
    do_op(4'd12, 32'h0D, 32'hAA, 5'd5, 1'b1);
    check("ram3", ram[3], 32'h0000_AA03);
    do_op(4'd4, 32'h0D, 32'h0, 5'd6, 1'b1);
    check("lb_val", wb_data, 32'hFFFF_FFAA);
    do_op(4'd5, 32'h0D, 32'h0, 5'd7, 1'b1);
    check("lbu_val", wb_data, 32'h0000_00AA);
    do_op(4'd10, 32'h12, 32'h8001, 5'd8, 1'b1);
    do_op(4'd2, 32'h12, 32'h0, 5'd9, 1'b1);
    check("lh_val", wb_data, 32'hFFFF_8001);
    check("ram4", ram[4], 32'h8001_0004);
    do_op(4'd3, 32'h12, 32'h0, 5'd10, 1'b1);
    check("lhu_val", wb_data, 32'h0000_8001);
    do_op(4'd1, 32'h06, 32'h0, 5'd11, 1'b1);
    do_op(4'd10, 32'h03, 32'h1234, 5'd12, 1'b1);
    do_op(4'd6, 32'h40, 32'h5555, 5'd13, 1'b1);
    check("ram0", ram[0], 32'h0);
    @(posedge clk); #1;
    check("idle_wbv", {31'd0, wb_valid}, 32'd0);

    // Reset in the write cycle must leave the RAM word untouched.
    in_valid = 1'b1; in_op = 4'd12; in_addr = 32'h21; in_wdata = 32'h77; in_da = 5'd14; in_rw = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rstrmw_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    #1;
    check("rstrmw_mw", {31'd0, MW}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("rstrmw_wbv", {31'd0, wb_valid}, 32'd0);
    check("rstrmw_wbdata", wb_data, 32'd0);
    check("rstrmw_wbda", {27'd0, wb_da}, 32'd0);
    check("rstrmw_wbrw", {31'd0, wb_rw}, 32'd0);
    check("rstrmw_wberr", {31'd0, wb_err}, 32'd0);
    check("rstrmw_ram", ram[8], ref_mem[8]);
    check("rstrmw_ready2", {31'd0, in_ready}, 32'd1);

    for (int n = 0; n < 300; n++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
      if ($urandom_range(0, 2) != 0) a[1] = 1'b0;
      do_op(op_tab[$urandom_range(0, 11)], a, $urandom, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
        check("gap_wbv", {31'd0, wb_valid}, 32'd0);
      end
    end

    for (int i = 0; i < DEPTH; i++) check("ram_final", ram[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
